lcd_refresh_scheduler: RTL and testbench
========================================

LCD_REFRESH_SCHEDULER -- requirements
Module: lcd_refresh_scheduler

Interface
REQ-001 SHALL have parameter VOP, default 8'hB1, contrast byte sent during init.
REQ-002 SHALL have parameter REFRESH_PERIOD, default 1_000_000, clk cycles between auto-refreshes.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port nrst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ready  input  1  SPI byte engine idle/accepting; synchronous to clk.
REQ-006 SHALL have port data_out  output  8  byte to the SPI engine.
REQ-007 SHALL have port enable  output  1  byte-issue request to the SPI engine.
REQ-008 SHALL have port mode  output  1  D/C select: 0 = command, 1 = display data.
REQ-009 SHALL have port fb_addr  output  9  frame-buffer read address, 0..503.
REQ-010 SHALL have port fb_data  input  8  frame-buffer read data, valid one clk after fb_addr.
REQ-011 SHALL have port refresh_req  input  1  one-cycle pulse requesting a full-frame refresh.
REQ-012 SHALL have ports init_done and busy  output  1 each: init complete; frame in progress.

Function
REQ-013 SHALL use states INIT, IDLE, ADDR, STREAM.
REQ-014 SHALL, in INIT, send the commands 8'h21, VOP, 8'h04, 8'h14, 8'h20, 8'h0C in order with mode=0, then go to IDLE and set init_done=1.
REQ-015 SHALL leave IDLE for ADDR on a pending refresh; busy=1 in ADDR and STREAM only.
REQ-016 SHALL, in ADDR, send 8'h80 then 8'h40 (X=0, Y=0) with mode=0, then enter STREAM.
REQ-017 SHALL, in STREAM, send 504 bytes fb_data[0..503] with mode=1, then return to IDLE.
REQ-018 SHALL drive fb_addr one clk ahead of use; fb_addr wraps 503 -> 0 at the end of the frame.
REQ-019 SHALL use a 4-phase byte handshake: wait for ready=1; assert enable with data_out and mode stable; hold all three until ready=0; deassert enable; wait for ready=1 before the next byte.
REQ-020 SHALL never assert enable while ready=0 at the issue point, and never change data_out or mode while enable=1.
REQ-021 SHALL latch refresh_req as a single pending flag; requests arriving while busy or in INIT merge into one refresh, serviced after the current activity.
REQ-022 SHALL treat refresh_req coincident with frame completion as pending; the next frame starts from IDLE with no lost request.

Reset
REQ-023 SHALL, on nrst=0, set enable=0, mode=0, data_out=0, fb_addr=0, init_done=0, busy=0, pending=0, auto-refresh counter=0, state=INIT.
REQ-024 SHALL abort any in-flight byte or frame when reset is asserted mid-operation; the full init sequence reruns after release.

Configuration
REQ-025 SHALL, with LCD_AUTO_REFRESH_EN defined, count clk cycles in IDLE and set pending when the count reaches REFRESH_PERIOD-1; the counter clears on any frame start.
REQ-026 SHALL, without LCD_AUTO_REFRESH_EN, omit the counter; refreshes come only from refresh_req.

Structure
REQ-027 SHALL place the following in package lcd_pkg: state enum, FRAME_BYTES=504, init command constants, and the address commands 8'h80 and 8'h40.
REQ-028 SHALL implement the 4-phase handshake in sub-module lcd_byte_issuer (start/byte/mode in, done out).

Verification
REQ-029 Reset release, ready-emulating SPI model: six bytes 21,B1,04,14,20,0C with mode=0, then init_done=1, busy=0.
REQ-030 refresh_req pulse after init, fb_data = low 8 bits of address: bytes 80,40 (mode=0), then 00..FF,00..F7 (mode=1), 504 bytes; then busy=0 and fb_addr=0.
REQ-031 Three refresh_req pulses during a frame: exactly one further frame follows.
REQ-032 SPI model holds ready low 50 cycles per byte: enable, data_out and mode stay stable until ready falls; no byte is duplicated or skipped.
REQ-033 nrst pulsed low at byte 200 of a frame: outputs reach reset values immediately; init sequence repeats; no frame without a new request (macro off).
REQ-034 LCD_AUTO_REFRESH_EN defined, REFRESH_PERIOD=100: a frame starts 100 cycles after entering IDLE, repeatedly, with no refresh_req.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and command constants for the PCD8544-style LCD refresh scheduler.
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ADDR,
    ST_STREAM
  } lcd_state_e;

  typedef enum logic [1:0] {
    BI_IDLE,
    BI_WAIT,
    BI_HOLD
  } issuer_state_e;

  localparam int unsigned FRAME_BYTES = 504;
  localparam int unsigned INIT_BYTES  = 6;
  localparam logic [8:0]  FRAME_LAST  = 9'(FRAME_BYTES - 1);
  localparam logic [8:0]  INIT_LAST   = 9'(INIT_BYTES - 1);
  localparam logic [8:0]  ADDR_LAST   = 9'd1;

  localparam logic [7:0] CMD_EXT_SET     = 8'h21;
  localparam logic [7:0] CMD_TEMP_COEF   = 8'h04;
  localparam logic [7:0] CMD_BIAS        = 8'h14;
  localparam logic [7:0] CMD_BASIC_SET   = 8'h20;
  localparam logic [7:0] CMD_DISP_NORMAL = 8'h0C;
  localparam logic [7:0] CMD_SET_X0      = 8'h80;
  localparam logic [7:0] CMD_SET_Y0      = 8'h40;

  // Init byte for a given position; the contrast byte comes from the instance.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx, input logic [7:0] vop);
    logic [7:0] cmd;
    case (idx)
      3'd0:    cmd = CMD_EXT_SET;
      3'd1:    cmd = vop;
      3'd2:    cmd = CMD_TEMP_COEF;
      3'd3:    cmd = CMD_BIAS;
      3'd4:    cmd = CMD_BASIC_SET;
      default: cmd = CMD_DISP_NORMAL;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/lcd_byte_issuer.sv
// Four-phase byte handshake towards the SPI engine: wait ready, raise enable,
// hold until ready drops, release. Byte and mode are frozen from start to done.
module lcd_byte_issuer
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       ready,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       tx_mode,
  output logic [7:0] data_out,
  output logic       mode,
  output logic       enable,
  output logic       done
);

  issuer_state_e state_q, state_d;
  logic [7:0]    data_q;
  logic          mode_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= BI_IDLE;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == BI_IDLE && start) begin
        data_q <= tx_byte;
        mode_q <= tx_mode;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BI_IDLE: if (start)  state_d = BI_WAIT;
      BI_WAIT: if (ready)  state_d = BI_HOLD;
      BI_HOLD: if (!ready) state_d = BI_IDLE;
      default:             state_d = BI_IDLE;
    endcase
  end

  always_comb begin
    enable   = (state_q == BI_HOLD);
    done     = (state_q == BI_HOLD) && !ready;
    data_out = data_q;
    mode     = mode_q;
  end

endmodule

// File: rtl/lcd_refresh_scheduler.sv
// LCD refresh scheduler: init sequence, then on request set X/Y and stream a
// 504-byte frame buffer. Optional auto-refresh via `LCD_AUTO_REFRESH_EN.
module lcd_refresh_scheduler
  import lcd_pkg::*;
#(
  parameter logic [7:0]  VOP            = 8'hB1,
  parameter int unsigned REFRESH_PERIOD = 1_000_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       ready,
  output logic [7:0] data_out,
  output logic       enable,
  output logic       mode,
  output logic [8:0] fb_addr,
  input  logic [7:0] fb_data,
  input  logic       refresh_req,
  output logic       init_done,
  output logic       busy
);

  lcd_state_e state_q, state_d;
  logic [8:0] idx_q, idx_d;
  logic [8:0] fb_addr_q, fb_addr_d;
  logic       pending_q, pending_d;
  logic       init_done_q, init_done_d;
  logic       issuing_q, issuing_d;

  logic       start;
  logic [7:0] tx_byte;
  logic       tx_mode;
  logic       byte_done;
  logic       last_byte;
  logic       frame_start;
  logic       auto_hit;

  lcd_byte_issuer u_issuer (
    .clk      (clk),
    .nrst     (nrst),
    .ready    (ready),
    .start    (start),
    .tx_byte  (tx_byte),
    .tx_mode  (tx_mode),
    .data_out (data_out),
    .mode     (mode),
    .enable   (enable),
    .done     (byte_done)
  );

`ifdef LCD_AUTO_REFRESH_EN
  logic [31:0] refresh_cnt_q, refresh_cnt_d;

  // Counter only runs while idle; any frame start or non-idle cycle clears it.
  always_comb begin
    auto_hit      = (state_q == ST_IDLE) && (refresh_cnt_q == 32'(REFRESH_PERIOD - 1));
    refresh_cnt_d = (state_q == ST_IDLE && !frame_start) ? refresh_cnt_q + 32'd1 : '0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) refresh_cnt_q <= '0;
    else       refresh_cnt_q <= refresh_cnt_d;
  end
`else
  logic [31:0] unused_period;
  assign unused_period = REFRESH_PERIOD;
  assign auto_hit      = 1'b0;
`endif

  assign frame_start = (state_q == ST_IDLE) && (pending_q || auto_hit);

  always_comb begin
    case (state_q)
      ST_INIT:   last_byte = (idx_q == INIT_LAST);
      ST_ADDR:   last_byte = (idx_q == ADDR_LAST);
      ST_STREAM: last_byte = (idx_q == FRAME_LAST);
      default:   last_byte = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (byte_done && last_byte) state_d = ST_IDLE;
      ST_IDLE:   if (frame_start)            state_d = ST_ADDR;
      ST_ADDR:   if (byte_done && last_byte) state_d = ST_STREAM;
      ST_STREAM: if (byte_done && last_byte) state_d = ST_IDLE;
      default:                               state_d = ST_INIT;
    endcase
  end

  always_comb begin
    busy    = (state_q == ST_ADDR) || (state_q == ST_STREAM);
    start   = (state_q != ST_IDLE) && !issuing_q;
    tx_mode = (state_q == ST_STREAM);
    case (state_q)
      ST_INIT:   tx_byte = init_cmd(idx_q[2:0], VOP);
      ST_ADDR:   tx_byte = idx_q[0] ? CMD_SET_Y0 : CMD_SET_X0;
      ST_STREAM: tx_byte = fb_data;
      default:   tx_byte = '0;
    endcase
  end

  // fb_addr advances when a stream byte is launched, so the next address is
  // presented several cycles before the memory data is consumed.
  always_comb begin
    issuing_d   = start || (issuing_q && !byte_done);
    idx_d       = idx_q;
    fb_addr_d   = fb_addr_q;
    init_done_d = init_done_q;
    pending_d   = refresh_req || (pending_q && !frame_start);
    if (byte_done) idx_d = last_byte ? '0 : idx_q + 9'd1;
    if (start && state_q == ST_STREAM)
      fb_addr_d = (fb_addr_q == FRAME_LAST) ? '0 : fb_addr_q + 9'd1;
    if (state_q == ST_INIT && byte_done && last_byte) init_done_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q       <= '0;
      fb_addr_q   <= '0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      issuing_q   <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      fb_addr_q   <= fb_addr_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
      issuing_q   <= issuing_d;
    end
  end

  assign fb_addr   = fb_addr_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Self-checking bench for lcd_refresh_scheduler with a handshaking SPI model and
// a synchronous frame-buffer model; auto-refresh scenario under LCD_AUTO_REFRESH_EN.
module tb_lcd_refresh_scheduler;

  localparam logic [7:0] VOP_T    = 8'hB1;
  localparam int         PERIOD_T = 100;
  localparam int         FRAME_N  = 506;

  logic       clk;
  logic       nrst;
  logic       ready;
  logic [7:0] data_out;
  logic       enable;
  logic       mode;
  logic [8:0] fb_addr;
  logic [7:0] fb_data;
  logic       refresh_req;
  logic       init_done;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [8:0] rx_q[$];
  logic [7:0] fb_mem [0:503];
  logic [7:0] init_ref [0:5] = '{8'h21, VOP_T, 8'h04, 8'h14, 8'h20, 8'h0C};

  int hold_min = 1, hold_max = 3, low_min = 0, low_max = 2;
  int viol      = 0;
  int addr_viol = 0;

  lcd_refresh_scheduler #(.VOP(VOP_T), .REFRESH_PERIOD(PERIOD_T)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .ready       (ready),
    .data_out    (data_out),
    .enable      (enable),
    .mode        (mode),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .refresh_req (refresh_req),
    .init_done   (init_done),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI engine model: accepts a byte on enable, drops ready after a hold,
  // keeps ready low for a configurable time, then re-arms once enable is low.
  initial begin
    int st = 0;
    int cnt = 0;
    logic [8:0] cur = '0;
    logic prev_en = 1'b0;
    ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!nrst) begin
        st = 0; ready = 1'b1; prev_en = 1'b0;
      end else begin
        if (enable && !prev_en && !ready) viol++;
        if (enable && prev_en && {mode, data_out} !== cur) viol++;
        if (fb_addr > 9'd503) addr_viol++;
        case (st)
          0: if (enable) begin
               cur = {mode, data_out};
               rx_q.push_back(cur);
               cnt = int'($urandom_range(hold_max, hold_min));
               st = 1;
             end
          1: if (!enable) begin
               viol++; st = 0;
             end else if (cnt <= 1) begin
               ready = 1'b0;
               cnt = int'($urandom_range(low_max, low_min));
               st = 2;
             end else cnt--;
          default: if (cnt > 0) cnt--;
                   else if (!enable) begin ready = 1'b1; st = 0; end
        endcase
        prev_en = enable;
      end
    end
  end

  // Synchronous frame-buffer: data for the address held in the previous cycle.
  initial begin
    logic [8:0] a_prev = '0;
    fb_data = '0;
    forever begin
      @(negedge clk);
      fb_data = (a_prev <= 9'd503) ? fb_mem[a_prev] : 8'hxx;
      a_prev  = fb_addr;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time exhausted, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int frame_mismatch(input int base);
    logic [8:0] exp;
    for (int i = 0; i < FRAME_N; i++) begin
      if (i == 0)      exp = {1'b0, 8'h80};
      else if (i == 1) exp = {1'b0, 8'h40};
      else             exp = {1'b1, fb_mem[i-2]};
      if (base + i >= rx_q.size()) return i;
      if (rx_q[base+i] !== exp) return i;
    end
    return -1;
  endfunction

  function automatic int init_mismatch();
    for (int i = 0; i < 6; i++) begin
      if (i >= rx_q.size()) return i;
      if (rx_q[i] !== {1'b0, init_ref[i]}) return i;
    end
    return -1;
  endfunction

  task automatic randomize_mem();
    for (int i = 0; i < 504; i++) fb_mem[i] = 8'($urandom);
  endtask

  task automatic pulse_refresh();
    @(negedge clk); refresh_req = 1'b1;
    @(negedge clk); refresh_req = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    int c = 0;
    ok = 1'b1;
    while (rx_q.size() < n) begin
      if (c >= budget) begin ok = 1'b0; break; end
      @(negedge clk); #1; c++;
    end
  endtask

  task automatic wait_busy(input logic lvl, input int budget, output bit ok, output int cycles);
    cycles = 0;
    ok = 1'b1;
    while (busy !== lvl) begin
      if (cycles >= budget) begin ok = 1'b0; break; end
      @(negedge clk); #1; cycles++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; refresh_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if ({enable, mode, data_out} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_spi: got en=%b mode=%b data=%h, expected 0/0/00", enable, mode, data_out);
    end
    tests_run++;
    if ({fb_addr, init_done, busy} !== 11'd0) begin
      tests_failed++;
      $display("FAIL reset_status: got fb_addr=%0d init_done=%b busy=%b, expected 0/0/0", fb_addr, init_done, busy);
    end
  endtask

  task automatic test_init();
    bit ok; int cyc; int mm;
    rx_q.delete();
    @(negedge clk); nrst = 1'b1;
    wait_bytes(6, 400, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL init_timeout: got %0d bytes, expected 6", rx_q.size()); end
    repeat (20) @(negedge clk);
    #1;
    mm = init_mismatch();
    tests_run++;
    if (mm != -1 || rx_q.size() != 6) begin
      tests_failed++;
      $display("FAIL init_bytes: first bad index %0d, count %0d, expected sequence 21,%h,04,14,20,0C mode 0", mm, rx_q.size(), VOP_T);
    end
    wait_busy(1'b0, 10, ok, cyc);
    tests_run++;
    if (init_done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL init_status: got init_done=%b busy=%b, expected 1/0", init_done, busy);
    end
  endtask

  task automatic test_frame_ramp();
    bit ok; int cyc; int mm;
    for (int i = 0; i < 504; i++) fb_mem[i] = i[7:0];
    rx_q.delete();
    pulse_refresh();
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL ramp_busy: got %b, expected 1", busy); end
    wait_bytes(FRAME_N, FRAME_N * 20, ok);
    wait_busy(1'b0, 60, ok, cyc);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL ramp_done: got busy=%b after %0d bytes, expected 0", busy, rx_q.size()); end
    tests_run++;
    if (fb_addr !== 9'd0) begin tests_failed++; $display("FAIL ramp_fb_addr: got %0d, expected 0", fb_addr); end
    repeat (300) @(negedge clk);
    mm = frame_mismatch(0);
    tests_run++;
    if (mm != -1 || rx_q.size() != FRAME_N) begin
      tests_failed++;
      $display("FAIL ramp_bytes: first bad index %0d, count %0d, expected 506", mm, rx_q.size());
    end
  endtask

  task automatic test_merge();
    bit ok; int cyc;
    randomize_mem();
    rx_q.delete();
    pulse_refresh();
    wait_bytes(100, 3000, ok);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(40, 5)) @(negedge clk);
      pulse_refresh();
    end
    wait_bytes(2 * FRAME_N, 2 * FRAME_N * 20, ok);
    wait_busy(1'b0, 60, ok, cyc);
    repeat (800) @(negedge clk);
    tests_run++;
    if (rx_q.size() != 2 * FRAME_N) begin
      tests_failed++;
      $display("FAIL merge_count: got %0d bytes, expected %0d", rx_q.size(), 2 * FRAME_N);
    end
    tests_run++;
    if (frame_mismatch(0) != -1 || frame_mismatch(FRAME_N) != -1) begin
      tests_failed++;
      $display("FAIL merge_bytes: got bad index %0d/%0d, expected -1/-1", frame_mismatch(0), frame_mismatch(FRAME_N));
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int cyc; int c;
    randomize_mem();
    rx_q.delete();
    pulse_refresh();
    wait_bytes(FRAME_N, FRAME_N * 20, ok);
    c = 0;
    while (ready !== 1'b0 && c < 20) begin @(negedge clk); #1; c++; end
    tests_run++;
    if (ready !== 1'b0) begin tests_failed++; $display("FAIL coincide_sync: got ready=%b, expected 0", ready); end
    refresh_req = 1'b1;
    @(negedge clk); refresh_req = 1'b0;
    wait_bytes(2 * FRAME_N, FRAME_N * 20, ok);
    wait_busy(1'b0, 60, ok, cyc);
    repeat (500) @(negedge clk);
    tests_run++;
    if (rx_q.size() != 2 * FRAME_N || frame_mismatch(FRAME_N) != -1) begin
      tests_failed++;
      $display("FAIL coincide_frame: got %0d bytes (bad index %0d), expected %0d", rx_q.size(), frame_mismatch(FRAME_N), 2 * FRAME_N);
    end
  endtask

  task automatic test_slow_spi();
    bit ok; int cyc; int v0; int mm;
    low_min = 50; low_max = 50;
    v0 = viol;
    randomize_mem();
    rx_q.delete();
    pulse_refresh();
    wait_bytes(FRAME_N, FRAME_N * 70, ok);
    wait_busy(1'b0, 200, ok, cyc);
    repeat (50) @(negedge clk);
    mm = frame_mismatch(0);
    tests_run++;
    if (mm != -1 || rx_q.size() != FRAME_N) begin
      tests_failed++;
      $display("FAIL slow_bytes: first bad index %0d, count %0d, expected 506", mm, rx_q.size());
    end
    tests_run++;
    if (viol != v0) begin tests_failed++; $display("FAIL slow_stability: got %0d violations, expected 0", viol - v0); end
    low_min = 0; low_max = 2;
  endtask

  task automatic test_reset_mid_frame();
    bit ok; int cyc;
    randomize_mem();
    rx_q.delete();
    pulse_refresh();
    wait_bytes(202, 202 * 20, ok);
    @(negedge clk); nrst = 1'b0;
    #1;
    tests_run++;
    if (enable !== 1'b0) begin tests_failed++; $display("FAIL abort_enable: got %b, expected 0", enable); end
    tests_run++;
    if ({mode, data_out, fb_addr, busy, init_done} !== 20'd0) begin
      tests_failed++;
      $display("FAIL abort_outputs: got mode=%b data=%h fb_addr=%0d busy=%b init_done=%b, expected all 0",
               mode, data_out, fb_addr, busy, init_done);
    end
    repeat (3) @(negedge clk);
    rx_q.delete();
    nrst = 1'b1;
    wait_bytes(6, 400, ok);
    wait_busy(1'b0, 10, ok, cyc);
    repeat (3000) @(negedge clk);
    tests_run++;
    if (init_mismatch() != -1 || rx_q.size() != 6) begin
      tests_failed++;
      $display("FAIL abort_reinit: got %0d bytes (bad index %0d), expected 6 init bytes only", rx_q.size(), init_mismatch());
    end
    tests_run++;
    if (init_done !== 1'b1) begin tests_failed++; $display("FAIL abort_init_done: got %b, expected 1", init_done); end
  endtask

  task automatic test_auto_refresh();
    bit ok; int c1; int c2; int cyc;
    rx_q.delete();
    wait_bytes(FRAME_N, FRAME_N * 20 + 400, ok);
    wait_busy(1'b0, 60, ok, cyc);
    wait_busy(1'b1, 400, ok, c1);
    wait_bytes(2 * FRAME_N, FRAME_N * 20, ok);
    wait_busy(1'b0, 60, ok, cyc);
    wait_busy(1'b1, 400, ok, c2);
    tests_run++;
    if (c1 != PERIOD_T) begin tests_failed++; $display("FAIL auto_gap1: got %0d cycles, expected %0d", c1, PERIOD_T); end
    tests_run++;
    if (c2 != PERIOD_T) begin tests_failed++; $display("FAIL auto_gap2: got %0d cycles, expected %0d", c2, PERIOD_T); end
    tests_run++;
    if (frame_mismatch(0) != -1 || frame_mismatch(FRAME_N) != -1) begin
      tests_failed++;
      $display("FAIL auto_bytes: got bad index %0d/%0d, expected -1/-1", frame_mismatch(0), frame_mismatch(FRAME_N));
    end
  endtask

  task automatic test_protocol();
    tests_run++;
    if (viol != 0) begin tests_failed++; $display("FAIL handshake: got %0d violations, expected 0", viol); end
    tests_run++;
    if (addr_viol != 0) begin tests_failed++; $display("FAIL fb_addr_range: got %0d out-of-range cycles, expected 0", addr_viol); end
  endtask

  initial begin
    nrst = 1'b0;
    refresh_req = 1'b0;
    randomize_mem();
    test_reset();
    test_init();
`ifdef LCD_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_frame_ramp();
    test_merge();
    test_back_to_back();
    test_slow_spi();
    test_reset_mid_frame();
`endif
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
